vga_pixfifo: RTL and testbench

//  Pixel-stream buffer that sits directly upstream of the low-level VGA timing

---
 rtl/vga_pkg.sv | 16 +
 rtl/vga_pixfifo_mem.sv | 22 ++
 rtl/vga_pixfifo.sv | 123 ++++++++++++
 tb/tb_vga_pixfifo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel path.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_SOF = 2'b00,
    ST_RUN      = 2'b01,
    ST_ERR      = 2'b10
  } state_e;

  localparam int unsigned DEF_ERR_PIXEL = 0;

  function automatic int unsigned bpp_f(input int unsigned bits_per_color);
    return 3 * bits_per_color;
  endfunction

endpackage

// File: rtl/vga_pixfifo_mem.sv
// Pixel storage: synchronous write port, asynchronous (combinational) read port.
module vga_pixfifo_mem #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 12
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vga_pixfifo.sv
// Pixel FIFO feeding the VGA timing stage: look-ahead output, underflow detect,
// resync on the next start-of-frame word after the timing stage signals a new frame.
module vga_pixfifo
  import vga_pkg::*;
#(
  parameter  int unsigned BITS_PER_COLOR = 4,
  parameter  int unsigned LGFIFO         = 10,
  parameter  int unsigned ERR_PIXEL      = DEF_ERR_PIXEL,
  localparam int unsigned BPP            = bpp_f(BITS_PER_COLOR)
) (
  input  logic              i_pixclk,
  input  logic              i_areset_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [BPP-1:0]    i_pixel,
  input  logic              i_sof,
  input  logic              i_rd,
  input  logic              i_newframe,
  output logic [BPP-1:0]    o_rgb_pix,
  output logic              o_underflow,
  output logic              o_sync,
  output logic [LGFIFO:0]   o_fill
);

  localparam logic [LGFIFO:0] DEPTH   = {1'b1, {LGFIFO{1'b0}}};
  localparam logic [BPP-1:0]  ERR_PIX = BPP'(ERR_PIXEL);

  state_e              state_q, state_d;
  logic [LGFIFO-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LGFIFO:0]     fill_q, fill_d;
  logic                underflow_q;
  logic                ready, push, pop, clear, uflow_evt;
  logic [LGFIFO-1:0]   raddr;
  logic [BPP-1:0]      rdata;

  always_ff @(posedge i_pixclk or negedge i_areset_n) begin
    if (!i_areset_n) state_q <= ST_WAIT_SOF;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_SOF: if (i_valid && i_sof)       state_d = ST_RUN;
      ST_RUN:      if (i_rd && fill_q == '0)   state_d = ST_ERR;
      ST_ERR:      if (i_newframe)             state_d = ST_WAIT_SOF;
      default:                                 state_d = ST_WAIT_SOF;
    endcase
  end

  // WAIT_SOF accepts everything but only keeps the SOF word.
  always_comb begin
    ready     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    clear     = 1'b0;
    uflow_evt = 1'b0;
    case (state_q)
      ST_WAIT_SOF: begin
        ready = 1'b1;
        push  = i_valid && i_sof;
      end
      ST_RUN: begin
        ready     = (fill_q < DEPTH);
        push      = i_valid && ready;
        pop       = i_rd && (fill_q != '0);
        uflow_evt = i_rd && (fill_q == '0);
      end
      ST_ERR:  clear = i_newframe;
      default: ;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) wr_ptr_d = wr_ptr_q + LGFIFO'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + LGFIFO'(1);
    case ({push, pop})
      2'b10:   fill_d = fill_q + (LGFIFO+1)'(1);
      2'b01:   fill_d = fill_q - (LGFIFO+1)'(1);
      default: ;
    endcase
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end
  end

  always_ff @(posedge i_pixclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      underflow_q <= uflow_evt;
    end
  end

  vga_pixfifo_mem #(.AW(LGFIFO), .DW(BPP)) u_mem (
    .clk_i   (i_pixclk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (i_pixel),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // Timing stage samples one cycle before its strobe, so read ahead by i_rd.
  assign raddr       = rd_ptr_q + LGFIFO'(i_rd);
  assign o_rgb_pix   = (state_q == ST_ERR || fill_q <= (LGFIFO+1)'(i_rd)) ? ERR_PIX : rdata;
  assign o_ready     = i_areset_n & ready;
  assign o_sync      = (state_q == ST_RUN);
  assign o_fill      = fill_q;
  assign o_underflow = underflow_q;

endmodule

// File: tb/tb_vga_pixfifo.sv
// Scoreboard bench for vga_pixfifo with directed stimulus.
module tb_vga_pixfifo;

  localparam int S_FILL = 0, S_RGB = 1, S_READY = 2, S_SYNC = 3, S_UFLOW = 4;

  typedef struct {
    int unsigned cyc;
    int          sel;
    logic [31:0] val;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_areset_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [11:0] i_pixel = '0;
  logic        i_sof = 1'b0;
  logic        i_rd = 1'b0;
  logic        i_newframe = 1'b0;
  logic        o_ready, o_underflow, o_sync;
  logic [11:0] o_rgb_pix;
  logic [10:0] o_fill;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  vga_pixfifo #(.BITS_PER_COLOR(4), .LGFIFO(10), .ERR_PIXEL(0)) dut (
    .i_pixclk    (clk),
    .i_areset_n  (i_areset_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_pixel     (i_pixel),
    .i_sof       (i_sof),
    .i_rd        (i_rd),
    .i_newframe  (i_newframe),
    .o_rgb_pix   (o_rgb_pix),
    .o_underflow (o_underflow),
    .o_sync      (o_sync),
    .o_fill      (o_fill)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: compares every expectation scheduled for the current cycle.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_chk++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.nm, e.cyc, cyc);
      end else begin
        case (e.sel)
          S_FILL:  act = {21'b0, o_fill};
          S_RGB:   act = {20'b0, o_rgb_pix};
          S_READY: act = {31'b0, o_ready};
          S_SYNC:  act = {31'b0, o_sync};
          default: act = {31'b0, o_underflow};
        endcase
        if (act !== e.val) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", e.nm, cyc, act, e.val);
        end
      end
    end
  end

  task automatic expect_now(input int sel, input logic [31:0] val, input string nm);
    exp_t e;
    e.cyc = cyc;
    e.sel = sel;
    e.val = val;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic step(input logic v, input logic [11:0] px, input logic sof,
                      input logic rd, input logic nf);
    @(posedge clk);
    #1;
    i_valid    = v;
    i_pixel    = px;
    i_sof      = sof;
    i_rd       = rd;
    i_newframe = nf;
  endtask

  function automatic logic [11:0] px_of(input int k);
    return 12'(k * 7 + 3);
  endfunction

  initial begin
    // Reset state
    step(0, 12'h000, 0, 0, 0);
    expect_now(S_FILL, 0, "rst_fill");
    expect_now(S_SYNC, 0, "rst_sync");
    expect_now(S_READY, 0, "rst_ready");
    expect_now(S_UFLOW, 0, "rst_uflow");
    expect_now(S_RGB, 0, "rst_rgb");
    step(0, 12'h000, 0, 0, 0);
    i_areset_n = 1'b1;

    // 1: non-SOF words accepted and discarded
    step(1, 12'hAAA, 0, 0, 0);  expect_now(S_READY, 1, "t1_ready_a");
    step(1, 12'hBBB, 0, 0, 0);  expect_now(S_READY, 1, "t1_ready_b");
    step(0, 12'h000, 0, 0, 0);
    expect_now(S_FILL, 0, "t1_fill");
    expect_now(S_SYNC, 0, "t1_sync");

    // 2: SOF starts a frame
    step(1, 12'h111, 1, 0, 0);  expect_now(S_READY, 1, "t2_ready");
    step(1, 12'h222, 0, 0, 0);
    expect_now(S_SYNC, 1, "t2_sync_early");
    expect_now(S_FILL, 1, "t2_fill1");
    step(1, 12'h333, 0, 0, 0);
    step(1, 12'h444, 0, 0, 0);
    step(0, 12'h000, 0, 0, 0);
    expect_now(S_FILL, 4, "t2_fill4");
    expect_now(S_SYNC, 1, "t2_sync");
    expect_now(S_RGB, 12'h111, "t2_rgb");

    // 3: look-ahead output while popping
    step(0, 12'h000, 0, 1, 0);
    expect_now(S_RGB, 12'h222, "t3_rgb0");  expect_now(S_FILL, 4, "t3_fill0");
    step(0, 12'h000, 0, 1, 0);
    expect_now(S_RGB, 12'h333, "t3_rgb1");  expect_now(S_FILL, 3, "t3_fill1");
    step(0, 12'h000, 0, 1, 0);
    expect_now(S_RGB, 12'h444, "t3_rgb2");  expect_now(S_FILL, 2, "t3_fill2");
    step(0, 12'h000, 0, 0, 0);
    expect_now(S_FILL, 1, "t3_fill_end");   expect_now(S_RGB, 12'h444, "t3_rgb_hold");

    // 4: drain, underflow, resync on newframe
    step(0, 12'h000, 0, 1, 0);
    expect_now(S_RGB, 0, "t4_rgb_last");    expect_now(S_FILL, 1, "t4_fill1");
    step(0, 12'h000, 0, 1, 0);
    expect_now(S_FILL, 0, "t4_fill0");      expect_now(S_UFLOW, 0, "t4_uflow_pre");
    step(1, 12'h777, 0, 0, 0);
    expect_now(S_UFLOW, 1, "t4_uflow");
    expect_now(S_READY, 0, "t4_ready_err");
    expect_now(S_RGB, 0, "t4_rgb_err");
    expect_now(S_SYNC, 0, "t4_sync_err");
    step(0, 12'h000, 0, 1, 0);
    expect_now(S_UFLOW, 0, "t4_uflow_once");
    expect_now(S_FILL, 0, "t4_fill_err");
    step(0, 12'h000, 0, 0, 1);
    expect_now(S_READY, 0, "t4_ready_nf");
    step(0, 12'h000, 0, 0, 0);
    expect_now(S_FILL, 0, "t4_fill_wait");
    expect_now(S_READY, 1, "t4_ready_wait");
    expect_now(S_SYNC, 0, "t4_sync_wait");

    // 5: fill to capacity, overflow word refused, one pop reopens
    for (int k = 0; k < 1024; k++) begin
      step(1, px_of(k), (k == 0), 0, 0);
      if (k == 0)    expect_now(S_READY, 1, "t5_ready_first");
      if (k == 1023) begin
        expect_now(S_READY, 1, "t5_ready_last");
        expect_now(S_FILL, 1023, "t5_fill_1023");
      end
    end
    step(1, 12'hFFF, 0, 0, 0);
    expect_now(S_READY, 0, "t5_ready_full");
    expect_now(S_FILL, 1024, "t5_fill_full");
    expect_now(S_RGB, px_of(0), "t5_rgb_head");
    step(0, 12'h000, 0, 1, 0);
    expect_now(S_READY, 0, "t5_ready_pop");
    expect_now(S_RGB, px_of(1), "t5_rgb_ahead");
    expect_now(S_FILL, 1024, "t5_fill_nowrite");
    step(0, 12'h000, 0, 0, 0);
    expect_now(S_FILL, 1023, "t5_fill_after");
    expect_now(S_READY, 1, "t5_ready_after");
    expect_now(S_RGB, px_of(1), "t5_rgb_after");

    // 6: async reset between edges
    @(posedge clk);
    #3;
    i_areset_n = 1'b0;
    expect_now(S_FILL, 0, "t6_fill");
    expect_now(S_SYNC, 0, "t6_sync");
    expect_now(S_READY, 0, "t6_ready");
    expect_now(S_RGB, 0, "t6_rgb");
    @(negedge clk);
    #2;
    i_areset_n = 1'b1;
    step(0, 12'h000, 0, 0, 0);
    expect_now(S_FILL, 0, "t6_fill_rel");
    expect_now(S_SYNC, 0, "t6_sync_rel");
    expect_now(S_READY, 1, "t6_ready_rel");
    step(1, 12'h555, 0, 0, 0);
    step(0, 12'h000, 0, 0, 0);
    expect_now(S_FILL, 0, "t6_discard");
    expect_now(S_SYNC, 0, "t6_still_wait");
    step(1, 12'h666, 1, 0, 0);
    step(0, 12'h000, 0, 0, 0);
    expect_now(S_SYNC, 1, "t6_resync");
    expect_now(S_FILL, 1, "t6_fill_sof");
    expect_now(S_RGB, 12'h666, "t6_rgb_sof");

    step(0, 12'h000, 0, 0, 0);
    step(0, 12'h000, 0, 0, 0);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s: expectation left unchecked", e.nm);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
